rom_port_arbiter: RTL and testbench
===================================

# rom_port_arbiter

Shares the single port of the 1 MB ROM-Flash (region 0x0800_0000–0x080F_FFFF) between the core's instruction-fetch requester and its data load/store requester. Sequences each access through a three-state machine and drives the memory's address, write-data and write-enable lines. Captures the memory's read data and returns a response to the granted requester. Addresses outside the ROM region are answered with an error and never reach the memory.

## Interface
- `ROM_TAG`, default 12'h080: value of address[31:20] that selects the ROM.
- `MAX_STREAK`, default 4: maximum consecutive data grants while fetch is waiting.
- `ALLOW_WRITE`, default 1: 1 lets data writes reach the ROM (flash programming); 0 turns them into errors.
- `clock`, in, 1: single clock. Reset is asynchronous and active-low.
- `reset_n`, in, 1: asynchronous active-low reset.
- `if_req`, in, 1: fetch request; held with `if_addr` until accepted.
- `if_addr`, in, 32: fetch byte address.
- `if_ready`, out, 1: fetch request accepted this cycle.
- `if_rvalid`, out, 1: one-cycle fetch response strobe.
- `if_rdata`, out, 32: fetch read data.
- `if_err`, out, 1: fetch response is an error.
- `d_req`, in, 1: data request; `d_we`, `d_addr`, `d_wdata` held with it until accepted.
- `d_we`, in, 1: 1 = write, 0 = read.
- `d_addr`, in, 32: data byte address.
- `d_wdata`, in, 32: data write value.
- `d_ready`, out, 1: data request accepted this cycle.
- `d_rvalid`, out, 1: one-cycle data response strobe.
- `d_rdata`, out, 32: data read data.
- `d_err`, out, 1: data response is an error.
- `mem_addr`, out, 32: memory address.
- `mem_wdata`, out, 32: memory write data.
- `mem_we`, out, 1: memory write enable.
- `mem_rdata`, in, 32: memory read data. Valid only while `clock` is high in the cycle after the memory's sampling edge; tri-stated otherwise.

## Operation
- States:
  - IDLE: accepts a request.
  - ACCESS: memory samples the registered `mem_*` lines at the edge that ends this state.
  - RESP: read data is captured, then the response is issued.
- Transitions: IDLE→ACCESS on an accepted request; ACCESS→RESP unconditionally; RESP→IDLE unconditionally.
- Ready signals:
  - `if_ready` and `d_ready` are combinational and are only asserted in IDLE.
  - At most one is high per cycle.
  - A ready is never asserted without the matching req.
- Priority:
  - Data wins over fetch.
  - Exception: when the streak counter equals `MAX_STREAK` and `if_req`=1, fetch wins.
- Streak counter:
  - Increments on each data grant while `if_req`=1.
  - Clears on a fetch grant, or in any IDLE cycle with `if_req`=0.
  - Saturates at `MAX_STREAK`.
- On accept, the arbiter registers `mem_addr`, `mem_we` and `mem_wdata` from the winner. Fetch always uses `mem_we`=0.
- Outside ACCESS and RESP:
  - `mem_addr` = 32'h0, which mismatches `ROM_TAG`, so the memory performs no access.
  - `mem_we` = 0.
- Error accepts leave `mem_*` at idle values and still walk the full state sequence. An error accept is either:
  - an address with address[31:20] ≠ `ROM_TAG`, or
  - a write when `ALLOW_WRITE`=0.
- Read data is captured from `mem_rdata` into a falling-edge register in the middle of the RESP cycle.
- Response rules:
  - On the RESP→IDLE edge, assert the owner's rvalid for exactly one cycle.
  - Read: rdata = captured value.
  - Write or error: rdata = 32'h0.
  - err = 1 only for error accepts.
- rdata holds its value until the next response to the same port.

## Timing
- Reset values: all outputs are 0, the state is IDLE, the streak counter is 0, and captured data is 0.
- Reset mid-access aborts the access. No rvalid is issued for the aborted request, and `mem_we` drops immediately.
- Cycle-level sequence:
  - Accept at edge E0.
  - `mem_*` stable from E0 to E2.
  - Memory acts at E1.
  - Capture at the falling edge between E1 and E2.
  - rvalid is high from E2 to E3.
  - The next accept can happen at E3 at the earliest.
- Throughput is one access per three cycles.
- If both requesters assert req in the same IDLE cycle, the priority rule decides. The loser's req stays pending and is served in a later IDLE.
- A req dropped before ready is not an error; nothing is issued.

## Structure
- Shared package `fpga_arm_mem_pkg` holds:
  - the `ROM_TAG` constant;
  - the ROM base/size constants (0x0800_0000, 1 MB);
  - the state encoding (IDLE/ACCESS/RESP);
  - the owner encoding (FETCH/DATA).
- One sub-module, `rom_port_prio`: combinational winner selection plus the streak counter register.

## Test plan
- Reset mid-ACCESS with a data read to 0x0800_0010 in flight → no rvalid; after reset release all outputs are 0 and `mem_addr`=0.
- Single fetch of 0x0800_0004 (memory word = 32'hE3A0_0001) → `if_ready` at E0, `mem_addr`=0x0800_0004 from E0 to E2, `if_rvalid` with `if_rdata`=32'hE3A0_0001 in the cycle after E2, `if_err`=0.
- Data write of 32'hDEAD_BEEF to 0x0800_0020, then a data read of the same address → `mem_we`=1 for exactly 2 cycles; write response has rdata=0 and err=0; read returns 32'hDEAD_BEEF.
- Data read of 0x2000_0000 → `d_err`=1, `d_rdata`=0, `mem_we` stays 0, `mem_addr` stays 0 throughout.
- `if_req` and `d_req` held continuously → grant order D,D,D,D,F,D,D,D,D,F.
- `ALLOW_WRITE`=0 with a data write to 0x0800_0000 → `d_err`=1 and memory contents unchanged.

Source files
------------

// File: rtl/fpga_arm_mem_pkg.sv
// Shared definitions for the ROM-Flash port logic.
//   ROM_BASE / ROM_SIZE : 1 MB ROM-Flash window at 0x0800_0000
//   ROM_TAG_DEF         : address[31:20] value that selects the ROM
//   arb_state_e         : access sequencer states (IDLE/ACCESS/RESP)
//   owner_e             : which requester owns the current access
//   addr_hits_rom()     : region decode helper
package fpga_arm_mem_pkg;

  localparam logic [31:0] ROM_BASE    = 32'h0800_0000;
  localparam logic [31:0] ROM_SIZE    = 32'h0010_0000;
  localparam logic [11:0] ROM_TAG_DEF = ROM_BASE[31:20];

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_e;

  // The ROM is 1 MB aligned, so the top 12 address bits fully decode it.
  function automatic logic addr_hits_rom(input logic [31:0] addr,
                                         input logic [11:0] tag);
    return (addr[31:20] == tag);
  endfunction

endpackage

// File: rtl/rom_port_prio.sv
// Winner selection between the fetch and data requesters, plus the streak
// counter that stops a busy data port from starving fetch.
//   clock, reset_n : clock, asynchronous active-low reset
//   idle           : arbiter is in IDLE and may grant this cycle
//   if_req, d_req  : pending requests
//   grant_fetch    : fetch wins this cycle (combinational)
//   grant_data     : data wins this cycle (combinational)
module rom_port_prio #(
  parameter int unsigned MAX_STREAK = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic idle,
  input  logic if_req,
  input  logic d_req,
  output logic grant_fetch,
  output logic grant_data
);

  localparam int SW = (MAX_STREAK < 1) ? 1 : $clog2(MAX_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);

  logic [SW-1:0] streak_reg;
  logic [SW-1:0] streak_next;
  logic          fetch_turn;

  always_comb begin
    // Data normally wins; fetch takes the slot once data has been granted
    // MAX_STREAK times in a row while fetch was waiting.
    fetch_turn  = if_req && (streak_reg == STREAK_MAX);
    grant_data  = idle && d_req && !fetch_turn;
    grant_fetch = idle && if_req && !grant_data;

    streak_next = streak_reg;
    if (idle) begin
      if (!if_req || grant_fetch) begin
        streak_next = '0;
      end else if (grant_data && (streak_reg != STREAK_MAX)) begin
        streak_next = streak_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      streak_reg <= '0;
    end else begin
      streak_reg <= streak_next;
    end
  end

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares the single ROM-Flash port between the instruction-fetch and the
// data load/store requesters. Each access walks IDLE -> ACCESS -> RESP;
// the memory samples the registered mem_* lines at the end of ACCESS and
// drives read data during the high phase of RESP, which is captured on
// the falling edge. Out-of-region addresses (and writes when ALLOW_WRITE=0)
// are answered with an error without ever touching the memory.
//   clock, reset_n                      : clock, asynchronous active-low reset
//   if_req/if_addr -> if_ready          : fetch request / accept
//   if_rvalid/if_rdata/if_err           : fetch response
//   d_req/d_we/d_addr/d_wdata -> d_ready: data request / accept
//   d_rvalid/d_rdata/d_err              : data response
//   mem_addr/mem_wdata/mem_we/mem_rdata : ROM-Flash port
module rom_port_arbiter
  import fpga_arm_mem_pkg::*;
#(
  parameter logic [11:0] ROM_TAG     = ROM_TAG_DEF,
  parameter int unsigned MAX_STREAK  = 4,
  parameter bit          ALLOW_WRITE = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  arb_state_e  state_reg;
  arb_state_e  state_next;
  owner_e      owner_reg;
  logic        err_reg;
  logic        write_reg;
  logic [31:0] capture_reg;

  logic        idle;
  logic        grant_fetch;
  logic        grant_data;
  logic [31:0] sel_addr;
  logic        sel_we;
  logic        accept_err;
  logic [31:0] resp_data;

  assign idle = (state_reg == ST_IDLE);

  rom_port_prio #(
    .MAX_STREAK (MAX_STREAK)
  ) u_prio (
    .clock       (clock),
    .reset_n     (reset_n),
    .idle        (idle),
    .if_req      (if_req),
    .d_req       (d_req),
    .grant_fetch (grant_fetch),
    .grant_data  (grant_data)
  );

  assign if_ready = grant_fetch;
  assign d_ready  = grant_data;

  always_comb begin
    sel_addr   = grant_data ? d_addr : if_addr;
    sel_we     = grant_data && d_we;
    accept_err = !addr_hits_rom(sel_addr, ROM_TAG) || (sel_we && !ALLOW_WRITE);
    // Writes and errors return zero; only clean reads return captured data.
    resp_data  = (write_reg || err_reg) ? 32'h0 : capture_reg;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (grant_fetch || grant_data) state_next = ST_ACCESS;
      ST_ACCESS: state_next = ST_RESP;
      ST_RESP:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
      owner_reg <= OWN_FETCH;
      err_reg   <= 1'b0;
      write_reg <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      mem_we    <= 1'b0;
      if_rvalid <= 1'b0;
      if_rdata  <= 32'h0;
      if_err    <= 1'b0;
      d_rvalid  <= 1'b0;
      d_rdata   <= 32'h0;
      d_err     <= 1'b0;
    end else begin
      state_reg <= state_next;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (grant_fetch || grant_data) begin
            owner_reg <= grant_data ? OWN_DATA : OWN_FETCH;
            err_reg   <= accept_err;
            write_reg <= sel_we;
            // Error accepts keep the port at its idle values (addr 0 never
            // decodes as ROM), but still take the full three cycles.
            if (!accept_err) begin
              mem_addr  <= sel_addr;
              mem_we    <= sel_we;
              mem_wdata <= sel_we ? d_wdata : 32'h0;
            end
          end
        end
        ST_RESP: begin
          mem_addr  <= 32'h0;
          mem_wdata <= 32'h0;
          mem_we    <= 1'b0;
          if (owner_reg == OWN_DATA) begin
            d_rvalid <= 1'b1;
            d_rdata  <= resp_data;
            d_err    <= err_reg;
          end else begin
            if_rvalid <= 1'b1;
            if_rdata  <= resp_data;
            if_err    <= err_reg;
          end
        end
        default: ;
      endcase
    end
  end

  // mem_rdata is only driven while clock is high in RESP, so sample it on
  // the falling edge in the middle of that cycle.
  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      capture_reg <= 32'h0;
    end else if ((state_reg == ST_RESP) && !write_reg && !err_reg) begin
      capture_reg <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Self-checking bench for rom_port_arbiter: directed table, multi-cycle
// corner sequences, an ALLOW_WRITE=0 instance, and a randomized run checked
// against a transaction-level reference model.
module tb_rom_port_arbiter;

  localparam int MAXS = 4;

  logic        clock;
  logic        reset_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready, if_rvalid, if_err;
  logic [31:0] if_rdata;
  logic        d_req, d_we;
  logic [31:0] d_addr, d_wdata;
  logic        d_ready, d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  logic        ro_d_req, ro_d_we;
  logic [31:0] ro_d_addr, ro_d_wdata;
  logic        ro_if_ready, ro_if_rvalid, ro_if_err;
  logic [31:0] ro_if_rdata;
  logic        ro_d_ready, ro_d_rvalid, ro_d_err;
  logic [31:0] ro_d_rdata;
  logic [31:0] ro_mem_addr, ro_mem_wdata;
  logic        ro_mem_we;
  logic [31:0] ro_mem_rdata;

  int n_chk = 0;
  int n_err = 0;

  rom_port_arbiter dut (
    .clock(clock), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  rom_port_arbiter #(.ALLOW_WRITE(1'b0)) dut_ro (
    .clock(clock), .reset_n(reset_n),
    .if_req(1'b0), .if_addr(32'h0), .if_ready(ro_if_ready),
    .if_rvalid(ro_if_rvalid), .if_rdata(ro_if_rdata), .if_err(ro_if_err),
    .d_req(ro_d_req), .d_we(ro_d_we), .d_addr(ro_d_addr), .d_wdata(ro_d_wdata),
    .d_ready(ro_d_ready), .d_rvalid(ro_d_rvalid), .d_rdata(ro_d_rdata), .d_err(ro_d_err),
    .mem_addr(ro_mem_addr), .mem_wdata(ro_mem_wdata), .mem_we(ro_mem_we),
    .mem_rdata(ro_mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- ROM-Flash device model ----------------
  function automatic logic [31:0] init_word(input bit [17:0] k);
    return (k == 18'd1) ? 32'hE3A0_0001 : {12'h5A5, k, 2'b00};
  endfunction

  logic [31:0] dev_mem [bit [17:0]];
  logic [31:0] s_addr = '0;
  logic [31:0] s_wdata = '0;
  logic        s_we = 1'b0;
  int          ro_we_seen = 0;

  // Line values just before each rising edge are what the memory sees.
  always @(negedge clock) begin
    s_addr  = mem_addr;
    s_we    = mem_we;
    s_wdata = mem_wdata;
    if (ro_mem_we) ro_we_seen++;
  end

  initial begin
    mem_rdata    = 32'hBAD0_BAD0;
    ro_mem_rdata = 32'h1357_9BDF;
  end

  always begin
    @(posedge clock);
    if (reset_n && s_addr[31:20] == 12'h080) begin
      if (s_we) begin
        dev_mem[s_addr[19:2]] = s_wdata;
      end else begin
        mem_rdata = dev_mem.exists(s_addr[19:2]) ? dev_mem[s_addr[19:2]]
                                                  : init_word(s_addr[19:2]);
        @(negedge clock);
        #1;
        mem_rdata = 32'hBAD0_BAD0;
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          port;      // 0 = fetch, 1 = data
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          exp_err;
    logic [31:0] exp_rdata;
    int          exp_we_cyc;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  task automatic do_txn(input int idx, input vec_t v);
    int w;
    int we_cnt;
    @(negedge clock);
    if (v.port) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    #1;
    w = 0;
    while (!(v.port ? d_ready : if_ready) && w < 20) begin
      @(negedge clock); #1; w++;
    end
    chk("txn_ready", v.port ? d_ready : if_ready, 1);
    chk("txn_ready_other", v.port ? if_ready : d_ready, 0);
    we_cnt = 0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clock);
      if_req = 1'b0; d_req = 1'b0;
      #1;
      if (mem_we) we_cnt++;
      if (c < 3) begin
        chk("txn_mem_addr", mem_addr, v.exp_err ? 32'h0 : v.addr);
        chk("txn_busy_rvalid", {if_rvalid, d_rvalid}, 0);
      end
    end
    chk("txn_rvalid", v.port ? d_rvalid : if_rvalid, 1);
    chk("txn_rvalid_other", v.port ? if_rvalid : d_rvalid, 0);
    chk("txn_rdata", v.port ? d_rdata : if_rdata, v.exp_rdata);
    chk("txn_err", v.port ? d_err : if_err, v.exp_err);
    chk("txn_we_cycles", we_cnt, v.exp_we_cyc);
    chk("txn_idle_mem_addr", mem_addr, 0);
    $display("txn %0d port=%s we=%0d addr=%h rdata=%h err=%0d",
             idx, v.port ? "D" : "F", v.we, v.addr,
             v.port ? d_rdata : if_rdata, v.port ? d_err : if_err);
  endtask

  task automatic ro_txn(input bit we, input logic [31:0] addr,
                        input bit exp_err, input logic [31:0] exp_rd);
    int w;
    @(negedge clock);
    ro_d_req = 1'b1; ro_d_we = we; ro_d_addr = addr; ro_d_wdata = 32'hCAFE_F00D;
    #1;
    w = 0;
    while (!ro_d_ready && w < 20) begin
      @(negedge clock); #1; w++;
    end
    chk("ro_ready", ro_d_ready, 1);
    @(negedge clock); ro_d_req = 1'b0; #1;
    chk("ro_mem_addr", ro_mem_addr, exp_err ? 32'h0 : addr);
    @(negedge clock); #1;
    @(negedge clock); #1;
    chk("ro_rvalid", ro_d_rvalid, 1);
    chk("ro_err", ro_d_err, exp_err);
    chk("ro_rdata", ro_d_rdata, exp_rd);
    chk("ro_if_side", {ro_if_ready, ro_if_rvalid, ro_if_err}, 0);
    $display("ro txn we=%0d addr=%h rdata=%h err=%0d", we, addr, ro_d_rdata, ro_d_err);
  endtask

  // ---------------- reference model (random phase) ----------------
  logic [31:0] ref_mem [bit [17:0]];

  function automatic logic [31:0] ref_rd(input bit [17:0] k);
    return ref_mem.exists(k) ? ref_mem[k] : init_word(k);
  endfunction

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 7))
      0:       return 32'h2000_0000 + ($urandom_range(0, 3) << 2);
      1:       return 32'h0810_0000;
      2:       return 32'h07FF_FFFC;
      3:       return 32'h080F_FFFC;
      default: return 32'h0800_0000 + ($urandom_range(0, 7) << 2);
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    bit [9:0]    order;
    int          ngr, w;
    bit          rv_seen;
    bit          f_act, d_act, d_we_r;
    logic [31:0] f_a, d_a, d_wd, acc_addr;
    bit          m_infl, m_port, m_err, rsp, e_fr, e_dr, acc_we;
    int          m_cnt, m_streak;
    logic [31:0] m_rd, m_if_rdata, m_d_rdata;
    bit          m_if_err, m_d_err;

    reset_n = 1'b0;
    if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    ro_d_req = 0; ro_d_we = 0; ro_d_addr = 0; ro_d_wdata = 0;

    vecs[0]  = '{0, 0, 32'h0800_0004, 32'h0,         0, 32'hE3A0_0001, 0};
    vecs[1]  = '{1, 1, 32'h0800_0020, 32'hDEAD_BEEF, 0, 32'h0,         2};
    vecs[2]  = '{1, 0, 32'h0800_0020, 32'h0,         0, 32'hDEAD_BEEF, 0};
    vecs[3]  = '{1, 0, 32'h2000_0000, 32'h0,         1, 32'h0,         0};
    vecs[4]  = '{0, 0, 32'h0810_0000, 32'h0,         1, 32'h0,         0};
    vecs[5]  = '{0, 0, 32'h07FF_FFFC, 32'h0,         1, 32'h0,         0};
    vecs[6]  = '{1, 0, 32'h080F_FFFC, 32'h0,         0, 32'h5A5F_FFFC, 0};
    vecs[7]  = '{1, 1, 32'h2000_0004, 32'h1111_2222, 1, 32'h0,         0};
    vecs[8]  = '{0, 0, 32'h0800_0020, 32'h0,         0, 32'hDEAD_BEEF, 0};
    vecs[9]  = '{1, 1, 32'h0800_0000, 32'h1234_5678, 0, 32'h0,         2};
    vecs[10] = '{1, 0, 32'h0800_0000, 32'h0,         0, 32'h1234_5678, 0};
    vecs[11] = '{0, 0, 32'h0800_0000, 32'h0,         0, 32'h1234_5678, 0};

    // Reset values.
    repeat (3) @(negedge clock);
    #1;
    chk("rst_ctl", {if_ready, if_rvalid, if_err, d_ready, d_rvalid, d_err, mem_we}, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    @(negedge clock);
    reset_n = 1'b1;

    // Reset in the middle of an ACCESS aborts the data read.
    @(negedge clock);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0800_0010;
    #1;
    w = 0;
    while (!d_ready && w < 20) begin @(negedge clock); #1; w++; end
    chk("abort_ready", d_ready, 1);
    @(negedge clock); d_req = 1'b0; #1;
    chk("abort_access_addr", mem_addr, 32'h0800_0010);
    reset_n = 1'b0;
    #1;
    chk("abort_mem_we", mem_we, 0);
    chk("abort_mem_addr", mem_addr, 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    rv_seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock); #1;
      rv_seen = rv_seen | if_rvalid | d_rvalid;
    end
    chk("abort_no_rvalid", rv_seen, 0);
    chk("abort_outputs", {if_err, d_err, mem_we, if_ready, d_ready}, 0);
    chk("abort_rdata", if_rdata | d_rdata, 0);
    chk("abort_mem_addr_after", mem_addr, 0);
    $display("txn abort data read addr=08000010 rvalid_seen=%0d", rv_seen);

    // Directed table.
    for (int i = 0; i < NV; i++) do_txn(i, vecs[i]);

    // Both requesters held: grant order D,D,D,D,F,D,D,D,D,F.
    @(negedge clock);
    if_req = 1'b1; if_addr = 32'h0800_0008;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0800_000C;
    order = '0; ngr = 0; w = 0;
    #1;
    while (ngr < 10 && w < 60) begin
      if (if_ready || d_ready) begin
        chk("hold_one_ready", {if_ready, d_ready} == 2'b11, 0);
        order = {order[8:0], d_ready};
        ngr++;
      end
      @(negedge clock); #1; w++;
    end
    chk("hold_grant_order", order, 10'b1111011110);
    $display("txn hold grants=%0d order=%b", ngr, order);
    if_req = 1'b0; d_req = 1'b0;
    repeat (4) @(negedge clock);

    // ALLOW_WRITE=0 instance.
    ro_txn(1'b0, 32'h0800_0000, 1'b0, 32'h1357_9BDF);
    ro_txn(1'b1, 32'h0800_0000, 1'b1, 32'h0);
    chk("ro_no_mem_we", ro_we_seen, 0);
    chk("ro_mem_wdata", ro_mem_wdata, 0);
    chk("ro_if_rdata", ro_if_rdata, 0);
    ro_txn(1'b1, 32'h2000_0000, 1'b1, 32'h0);

    // Randomized run against the reference model, from a fresh reset.
    @(negedge clock);
    reset_n = 1'b0;
    dev_mem.delete();
    ref_mem.delete();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    f_act = 0; d_act = 0; d_we_r = 0; f_a = 0; d_a = 0; d_wd = 0;
    m_infl = 0; m_cnt = 0; m_port = 0; m_err = 0; m_rd = 0; m_streak = 0;
    m_if_rdata = 0; m_d_rdata = 0; m_if_err = 0; m_d_err = 0;
    for (int cyc = 0; cyc < 900; cyc++) begin
      @(negedge clock);
      if (cyc >= 890) begin
        f_act = 0; d_act = 0;
      end else begin
        if (!f_act) begin
          if ($urandom_range(0, 2) == 0) begin f_act = 1; f_a = rand_addr(); end
        end else if ($urandom_range(0, 19) == 0) f_act = 0;
        if (!d_act) begin
          if ($urandom_range(0, 1) == 0) begin
            d_act = 1; d_a = rand_addr(); d_we_r = ($urandom_range(0, 2) == 0);
            d_wd = $urandom;
          end
        end else if ($urandom_range(0, 19) == 0) d_act = 0;
      end
      if_req = f_act; if_addr = f_a;
      d_req = d_act; d_we = d_we_r; d_addr = d_a; d_wdata = d_wd;
      #1;
      if (m_infl) m_cnt++;
      rsp = m_infl && (m_cnt == 3);
      if (rsp) begin
        m_infl = 0;
        if (m_port) begin m_d_rdata = m_rd; m_d_err = m_err; end
        else begin m_if_rdata = m_rd; m_if_err = m_err; end
      end
      chk("rnd_if_rvalid", if_rvalid, rsp && !m_port);
      chk("rnd_d_rvalid", d_rvalid, rsp && m_port);
      chk("rnd_if_rdata", if_rdata, m_if_rdata);
      chk("rnd_d_rdata", d_rdata, m_d_rdata);
      chk("rnd_err", {if_err, d_err}, {m_if_err, m_d_err});
      e_fr = 0; e_dr = 0;
      if (!m_infl) begin
        if (if_req && (!d_req || m_streak == MAXS)) e_fr = 1;
        else if (d_req) e_dr = 1;
        if (!if_req || e_fr) m_streak = 0;
        else if (e_dr && m_streak < MAXS) m_streak++;
      end
      chk("rnd_if_ready", if_ready, e_fr);
      chk("rnd_d_ready", d_ready, e_dr);
      chk("rnd_we_outside_rom", mem_we && (mem_addr[31:20] != 12'h080), 0);
      if (e_fr || e_dr) begin
        m_infl = 1; m_cnt = 0; m_port = e_dr;
        acc_addr = e_dr ? d_a : f_a;
        acc_we = e_dr && d_we_r;
        m_err = (acc_addr[31:20] != 12'h080);
        m_rd = 32'h0;
        if (!m_err) begin
          if (acc_we) ref_mem[acc_addr[19:2]] = d_wd;
          else m_rd = ref_rd(acc_addr[19:2]);
        end
        $display("rnd cyc=%0d port=%s we=%0d addr=%h exp_rdata=%h exp_err=%0d",
                 cyc, e_dr ? "D" : "F", acc_we, acc_addr, m_rd, m_err);
        if (e_dr) d_act = 0; else f_act = 0;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
